// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB requester arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    // Read data returned when the access-phase watchdog fires.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;

    // Width of the access-phase watchdog counter.
    localparam int unsigned CNT_WIDTH = 16;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module apb_rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 valid_c,
    output logic [IDX_WIDTH-1:0] idx_c
);

    int unsigned          cand;
    logic [IDX_WIDTH-1:0] cand_idx;

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        valid_c  = 1'b0;
        idx_c    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_WIDTH'(cand);
            if (!valid_c && req[cand_idx]) begin
                valid_c = 1'b1;
                idx_c   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/apb_requester_arbiter.sv
// Round-robin arbiter sharing one APB completer between NUM_REQ requesters.
// One transaction in flight; downstream setup/access is regenerated locally.
// Optional access-phase watchdog: define APB_ARB_TIMEOUT_EN.
module apb_requester_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
    localparam int unsigned IDX_WIDTH     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_psel,
    input  logic [NUM_REQ-1:0]            req_pwrite,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_paddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_pwdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_pstrb,
    output logic [NUM_REQ-1:0]            req_pready,
    output logic [DATA_WIDTH-1:0]         req_prdata,
    output logic                          req_pslverr,
    output logic                          apb_psel,
    output logic                          apb_penable,
    output logic                          apb_pwrite,
    output logic [ADDR_WIDTH-1:0]         apb_paddr,
    output logic [DATA_WIDTH-1:0]         apb_pwdata,
    output logic [STRB_WIDTH-1:0]         apb_pstrb,
    input  logic                          apb_pready,
    input  logic                          apb_pslverr,
    input  logic [DATA_WIDTH-1:0]         apb_prdata,
    output logic [IDX_WIDTH-1:0]          grant_idx
);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic [IDX_WIDTH-1:0] ptr_q;
    logic [IDX_WIDTH-1:0] ptr_d;
    logic                 pick_valid_c;
    logic [IDX_WIDTH-1:0] pick_idx_c;
    logic                 timeout_hit_c;

    logic                  apb_psel_d;
    logic                  apb_penable_d;
    logic                  apb_pwrite_d;
    logic [ADDR_WIDTH-1:0] apb_paddr_d;
    logic [DATA_WIDTH-1:0] apb_pwdata_d;
    logic [STRB_WIDTH-1:0] apb_pstrb_d;
    logic [NUM_REQ-1:0]    req_pready_d;
    logic [DATA_WIDTH-1:0] req_prdata_d;
    logic                  req_pslverr_d;
    logic [IDX_WIDTH-1:0]  grant_idx_d;

    apb_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (req_psel),
        .ptr     (ptr_q),
        .valid_c (pick_valid_c),
        .idx_c   (pick_idx_c)
    );

`ifdef APB_ARB_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] acc_cnt_q;

    // Count ACCESS cycles; held at zero elsewhere so every entry starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q <= '0;
        end else if (state_q == ACCESS) begin
            acc_cnt_q <= acc_cnt_q + CNT_WIDTH'(1);
        end else begin
            acc_cnt_q <= '0;
        end
    end

    assign timeout_hit_c = (state_q == ACCESS) && !apb_pready &&
                           (acc_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    // Keeps the watchdog configuration referenced when it is compiled out.
    localparam int unsigned unused_timeout_cfg = TIMEOUT_CYCLES + CNT_WIDTH + 32'(TIMEOUT_RDATA);
    assign timeout_hit_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid_c) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (apb_pready || timeout_hit_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs, pointer and captured request.
    always_comb begin
        apb_psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        apb_penable_d = (state_d == ACCESS);
        apb_pwrite_d  = apb_pwrite;
        apb_paddr_d   = apb_paddr;
        apb_pwdata_d  = apb_pwdata;
        apb_pstrb_d   = apb_pstrb;
        req_pready_d  = '0;
        req_prdata_d  = req_prdata;
        req_pslverr_d = req_pslverr;
        grant_idx_d   = grant_idx;
        ptr_d         = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    grant_idx_d  = pick_idx_c;
                    apb_pwrite_d = req_pwrite[pick_idx_c];
                    apb_paddr_d  = req_paddr[32'(pick_idx_c) * ADDR_WIDTH +: ADDR_WIDTH];
                    apb_pwdata_d = req_pwdata[32'(pick_idx_c) * DATA_WIDTH +: DATA_WIDTH];
                    apb_pstrb_d  = req_pstrb[32'(pick_idx_c) * STRB_WIDTH +: STRB_WIDTH];
                end
            end
            ACCESS: begin
                if (apb_pready) begin
                    req_pready_d  = NUM_REQ'(1) << grant_idx;
                    req_prdata_d  = apb_pwrite ? '0 : apb_prdata;
                    req_pslverr_d = apb_pslverr;
                end else if (timeout_hit_c) begin
                    req_pready_d  = NUM_REQ'(1) << grant_idx;
                    req_prdata_d  = DATA_WIDTH'(TIMEOUT_RDATA);
                    req_pslverr_d = 1'b1;
                end
            end
            DONE: begin
                ptr_d = (grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_WIDTH'(1);
            end
            default: ;
        endcase
    end

    // Output, holding and pointer registers; apb_pwrite/paddr/pwdata/pstrb hold the granted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwrite  <= 1'b0;
            apb_paddr   <= '0;
            apb_pwdata  <= '0;
            apb_pstrb   <= '0;
            req_pready  <= '0;
            req_prdata  <= '0;
            req_pslverr <= 1'b0;
            grant_idx   <= '0;
            ptr_q       <= '0;
        end else begin
            apb_psel    <= apb_psel_d;
            apb_penable <= apb_penable_d;
            apb_pwrite  <= apb_pwrite_d;
            apb_paddr   <= apb_paddr_d;
            apb_pwdata  <= apb_pwdata_d;
            apb_pstrb   <= apb_pstrb_d;
            req_pready  <= req_pready_d;
            req_prdata  <= req_prdata_d;
            req_pslverr <= req_pslverr_d;
            grant_idx   <= grant_idx_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Self-checking bench for apb_requester_arbiter against a transaction-level model.
// Watchdog section runs only when APB_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_apb_requester_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_psel;
    logic [N-1:0]    req_pwrite;
    logic [N*AW-1:0] req_paddr;
    logic [N*DW-1:0] req_pwdata;
    logic [N*SW-1:0] req_pstrb;
    logic [N-1:0]    req_pready;
    logic [DW-1:0]   req_prdata;
    logic            req_pslverr;
    logic            apb_psel;
    logic            apb_penable;
    logic            apb_pwrite;
    logic [AW-1:0]   apb_paddr;
    logic [DW-1:0]   apb_pwdata;
    logic [SW-1:0]   apb_pstrb;
    logic            apb_pready;
    logic            apb_pslverr;
    logic [DW-1:0]   apb_prdata;
    logic [IW-1:0]   grant_idx;

    apb_requester_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_psel(req_psel), .req_pwrite(req_pwrite), .req_paddr(req_paddr),
        .req_pwdata(req_pwdata), .req_pstrb(req_pstrb),
        .req_pready(req_pready), .req_prdata(req_prdata), .req_pslverr(req_pslverr),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
        .apb_pready(apb_pready), .apb_pslverr(apb_pslverr), .apb_prdata(apb_prdata),
        .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side model state
    logic [N-1:0]  psel_m;
    logic          m_write [N];
    logic [AW-1:0] m_addr  [N];
    logic [DW-1:0] m_wdata [N];
    logic [SW-1:0] m_strb  [N];
    int            m_wait  [N];
    int            ptr_m;
    int            last_w;
    logic [DW-1:0] last_rdata;
    logic          last_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_psel[i]            = psel_m[i];
            req_pwrite[i]          = m_write[i];
            req_paddr[i*AW +: AW]  = m_addr[i];
            req_pwdata[i*DW +: DW] = m_wdata[i];
            req_pstrb[i*SW +: SW]  = m_strb[i];
        end
    endtask

    task automatic raise(input int j, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        psel_m[j]  = 1'b1;
        m_write[j] = wr;
        m_addr[j]  = a;
        m_wdata[j] = d;
        m_strb[j]  = s;
        m_wait[j]  = 0;
        drive();
    endtask

    task automatic raise_random(input int j);
        raise(j, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, SW'($urandom));
    endtask

    // Round-robin rule: first pending requester at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N] == 1'b1) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_psel"},    apb_psel, 0);
        chk({tag, "_penable"}, apb_penable, 0);
        chk({tag, "_pwrite"},  apb_pwrite, 0);
        chk({tag, "_paddr"},   apb_paddr, 0);
        chk({tag, "_pwdata"},  apb_pwdata, 0);
        chk({tag, "_pstrb"},   apb_pstrb, 0);
        chk({tag, "_pready"},  req_pready, 0);
        chk({tag, "_prdata"},  req_prdata, 0);
        chk({tag, "_pslverr"}, req_pslverr, 0);
        chk({tag, "_grant"},   grant_idx, 0);
    endtask

    // One arbitration round starting in an IDLE cycle; ends in the following IDLE cycle.
    task automatic do_txn(input int ws, input logic [DW-1:0] rd, input logic er,
                          input logic [N-1:0] late, input bit rnd);
        int w;
        w = pick(psel_m, ptr_m);
        if (w < 0) begin
            step();
            chk("idle_psel", apb_psel, 0);
            return;
        end
        for (int j = 0; j < N; j++) begin
            if (j != w && psel_m[j]) begin
                m_wait[j]++;
                chk("rr_bound", 64'(m_wait[j] <= N - 1), 1);
            end
        end
        step();
        chk("setup_psel",    apb_psel, 1);
        chk("setup_penable", apb_penable, 0);
        chk("setup_pwrite",  apb_pwrite, m_write[w]);
        chk("setup_paddr",   apb_paddr, m_addr[w]);
        chk("setup_pwdata",  apb_pwdata, m_wdata[w]);
        chk("setup_pstrb",   apb_pstrb, m_strb[w]);
        chk("setup_grant",   grant_idx, 64'(w));
        chk("setup_pready",  req_pready, 0);
        apb_pready = 1'($urandom_range(0, 1));
        for (int j = 0; j < N; j++) begin
            if (late[j] && !psel_m[j] && j != w) raise_random(j);
        end
        if (rnd && $urandom_range(0, 3) == 0) begin
            psel_m[w] = 1'b0;
            drive();
        end
        step();
        apb_pready = 1'b0;
        for (int c = 0; c < ws; c++) begin
            chk("wait_psel",    apb_psel, 1);
            chk("wait_penable", apb_penable, 1);
            chk("wait_pready",  req_pready, 0);
            step();
        end
        chk("access_psel",    apb_psel, 1);
        chk("access_penable", apb_penable, 1);
        apb_pready  = 1'b1;
        apb_prdata  = rd;
        apb_pslverr = er;
        last_rdata  = m_write[w] ? '0 : rd;
        last_err    = er;
        step();
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        apb_prdata  = $urandom;
        chk("done_pready",  req_pready, 64'(N'(1) << w));
        chk("done_prdata",  req_prdata, last_rdata);
        chk("done_pslverr", req_pslverr, last_err);
        chk("done_psel",    apb_psel, 0);
        chk("done_penable", apb_penable, 0);
        ptr_m     = (w + 1) % N;
        m_wait[w] = 0;
        psel_m[w] = 1'b0;
        last_w    = w;
        if (rnd) begin
            for (int j = 0; j < N; j++) begin
                if (j == w) continue;
                if (psel_m[j] && $urandom_range(0, 7) == 0) psel_m[j] = 1'b0;
                else if (!psel_m[j] && $urandom_range(0, 1) == 1) raise_random(j);
            end
        end
        drive();
        step();
        chk("idle_pready",  req_pready, 0);
        chk("hold_prdata",  req_prdata, last_rdata);
        chk("hold_pslverr", req_pslverr, last_err);
        chk("hold_grant",   grant_idx, 64'(w));
    endtask

    initial begin
        psel_m = '0;
        for (int i = 0; i < N; i++) begin
            m_write[i] = 1'b0;
            m_addr[i]  = '0;
            m_wdata[i] = '0;
            m_strb[i]  = '0;
            m_wait[i]  = 0;
        end
        apb_pready  = 1'b0;
        apb_pslverr = 1'b0;
        apb_prdata  = '0;
        ptr_m       = 0;
        last_w      = 0;
        last_rdata  = '0;
        last_err    = 1'b0;
        drive();

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1 chk_zero("rst_async");
        repeat (3) step();
        chk_zero("rst_hold");
        rst = 1'b0;

        // Contention with pointer at 0: req0 then req1
        raise(0, 1'b1, 24'h000010, 32'h1111_1111, 4'hF);
        raise(1, 1'b1, 24'h000020, 32'h2222_2222, 4'hF);
        do_txn(0, 32'h0BAD_0001, 1'b0, '0, 1'b0);
        do_txn(0, 32'h0BAD_0002, 1'b0, '0, 1'b0);

        // Single read with two wait states
        raise(0, 1'b0, 24'h000104, 32'h0, 4'h0);
        do_txn(2, 32'hCAFE_BABE, 1'b0, '0, 1'b0);

        // Error response on a write
        raise(1, 1'b1, 24'hFFFFFC, 32'h5A5A_5A5A, 4'h3);
        do_txn(1, 32'h1234_5678, 1'b1, '0, 1'b0);

        // Fairness: req0 keeps requesting, req1 arrives once
        raise(0, 1'b0, 24'h000300, 32'h0, 4'h0);
        do_txn(0, $urandom, 1'b0, 2'b10, 1'b0);
        raise(0, 1'b1, 24'h000304, $urandom, 4'hF);
        do_txn(1, $urandom, 1'b0, '0, 1'b0);
        do_txn(0, $urandom, 1'b0, '0, 1'b0);

        // Reset while waiting in ACCESS
        raise(1, 1'b0, 24'h000400, 32'h0, 4'h0);
        step();
        step();
        step();
        rst = 1'b1;
        #1 chk_zero("rst_mid");
        step();
        chk("rst_mid_no_pready", req_pready, 0);
        psel_m = '0;
        drive();
        rst        = 1'b0;
        ptr_m      = 0;
        last_rdata = '0;
        last_err   = 1'b0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
        raise(0, 1'b0, 24'h000500, 32'h0, 4'h0);
        raise(1, 1'b0, 24'h000600, 32'h0, 4'h0);
        do_txn(0, 32'hA5A5_0000, 1'b0, '0, 1'b0);
        do_txn(0, 32'hA5A5_0001, 1'b0, '0, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < N; j++) begin
                if (!psel_m[j] && j != last_w && $urandom_range(0, 1) == 1) raise_random(j);
            end
            do_txn(int'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 7) == 0),
                   N'($urandom), 1'b1);
        end

`ifdef APB_ARB_TIMEOUT_EN
        // Completer never answers: watchdog ends the access
        begin
            int w;
            psel_m = '0;
            drive();
            step();
            raise(0, 1'b0, 24'h000700, 32'h0, 4'h0);
            w = pick(psel_m, ptr_m);
            step();
            chk("to_setup_psel", apb_psel, 1);
            for (int c = 0; c < TO; c++) begin
                step();
                chk("to_access_penable", apb_penable, 1);
                chk("to_access_pready", req_pready, 0);
            end
            step();
            chk("to_done_pready",  req_pready, 64'(N'(1) << w));
            chk("to_done_prdata",  req_prdata, 32'hDEAD_DEAD);
            chk("to_done_pslverr", req_pslverr, 1);
            chk("to_done_psel",    apb_psel, 0);
            psel_m[w] = 1'b0;
            drive();
            step();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
